inst_queue: RTL

Parametrised circular instruction queue between fetch and issue in the dual-issue MIPS core. It generalises the fixed two-in/two-out buffer to FETCH_W lanes in, ISSUE_W lanes out, and DEPTH entries. It adds compaction of sparse fetch masks, variable pop counts and an almost-full watermark. A single-cycle flush empties it on exception or branch redirect.

---
 rtl/inst_queue_pkg.sv | 24 ++
 rtl/inst_queue_if.sv | 35 +++
 rtl/inst_queue_compact.sv | 26 ++
 rtl/inst_queue.sv | 113 +++++++++++
 4 files changed

// File: rtl/inst_queue_pkg.sv
// Shared constants and width helpers for the instruction queue.
// No logic; compile-time only.
// No flow control of its own.
package inst_queue_pkg;

    localparam int ENTRY_W_DEF = 131;

    // Field offsets inside one entry: {predictor, inst, exc_vec, pc}
    localparam int PC_LSB   = 0;
    localparam int EXC_LSB  = 32;
    localparam int INST_LSB = 64;
    localparam int PRED_LSB = 96;

    // Bits needed to index n distinct values; never returns less than 1
    function automatic int clog2w(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/inst_queue_if.sv
// Fetch/issue side bundle of the instruction queue.
// Head and status signals are combinational from queue state.
// Fetch holds data while allowin_o is low; issue pops via pop_cnt_i.
interface inst_queue_if import inst_queue_pkg::*; #(
    parameter int DEPTH   = 16,
    parameter int ENTRY_W = ENTRY_W_DEF,
    parameter int FETCH_W = 2,
    parameter int ISSUE_W = 2
);
    localparam int POP_W = clog2w(ISSUE_W + 1);
    localparam int CNT_W = clog2w(DEPTH + 1);

    logic                       flush_i;
    logic [FETCH_W-1:0]         push_valid_i;
    logic [FETCH_W*ENTRY_W-1:0] push_data_i;
    logic                       allowin_o;
    logic                       almost_full_o;
    logic [POP_W-1:0]           pop_cnt_i;
    logic [ISSUE_W-1:0]         head_valid_o;
    logic [ISSUE_W*ENTRY_W-1:0] head_data_o;
    logic [CNT_W-1:0]           count_o;

    // Queue side
    modport slave (
        input  flush_i, push_valid_i, push_data_i, pop_cnt_i,
        output allowin_o, almost_full_o, head_valid_o, head_data_o, count_o
    );

    // Fetch/issue side
    modport master (
        output flush_i, push_valid_i, push_data_i, pop_cnt_i,
        input  allowin_o, almost_full_o, head_valid_o, head_data_o, count_o
    );

endinterface

// File: rtl/inst_queue_compact.sv
// Prefix popcount over the push lane mask: slot offset per lane plus total.
// Purely combinational, zero latency.
// No backpressure; the caller decides whether the push is accepted.
module iq_compact import inst_queue_pkg::*; #(
    parameter int FETCH_W = 2,
    parameter int OFF_W   = clog2w(FETCH_W + 1)
) (
    input  logic [FETCH_W-1:0]            valid_i,
    output logic [FETCH_W-1:0][OFF_W-1:0] off_o,
    output logic [OFF_W-1:0]              npush_o
);

    logic [OFF_W-1:0] acc;

    // Each lane lands at the number of valid lanes below it
    always_comb begin
        acc   = '0;
        off_o = '0;
        for (int k = 0; k < FETCH_W; k++) begin
            off_o[k] = acc;
            acc      = acc + OFF_W'(valid_i[k]);
        end
        npush_o = acc;
    end

endmodule

// File: rtl/inst_queue.sv
// Circular fetch-to-issue instruction queue with lane compaction and flush.
// Write-to-head latency 1 cycle; head/status outputs depend on state only.
// Whole push is dropped unless FETCH_W slots are free; pops are clamped to count.
module inst_queue import inst_queue_pkg::*; #(
    parameter int DEPTH    = 16,
    parameter int ENTRY_W  = ENTRY_W_DEF,
    parameter int FETCH_W  = 2,
    parameter int ISSUE_W  = 2,
    parameter int AF_SLACK = 4
) (
    input  logic       clk,
    input  logic       rst,
    inst_queue_if.slave q
);

    localparam int PTR_W = clog2w(DEPTH);
    localparam int CNT_W = clog2w(DEPTH + 1);
    localparam int OFF_W = clog2w(FETCH_W + 1);

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ENTRY_W-1:0] mem_q [DEPTH];

    logic [FETCH_W-1:0][OFF_W-1:0] lane_off;
    logic [OFF_W-1:0]              npush;
    logic [CNT_W-1:0]              free_slots;
    logic [CNT_W-1:0]              npush_acc;
    logic [CNT_W-1:0]              pop_req;
    logic [CNT_W-1:0]              eff_pop;
    logic                          allowin;
    logic                          almost_full;
    logic [FETCH_W-1:0]            wr_en;
    logic [FETCH_W-1:0][PTR_W-1:0] wr_idx;
    logic [ISSUE_W-1:0]            head_valid;
    logic [ISSUE_W*ENTRY_W-1:0]    head_data;

    iq_compact #(
        .FETCH_W (FETCH_W),
        .OFF_W   (OFF_W)
    ) u_compact (
        .valid_i (q.push_valid_i),
        .off_o   (lane_off),
        .npush_o (npush)
    );

    // Status flags look only at the registered count
    always_comb begin
        free_slots  = CNT_W'(DEPTH) - count_q;
        allowin     = (free_slots >= CNT_W'(FETCH_W));
        almost_full = (free_slots < CNT_W'(AF_SLACK));
    end

    // Pointer/count update; flush overrides this cycle's push and pop
    always_comb begin
        npush_acc = allowin ? CNT_W'(npush) : '0;
        pop_req   = CNT_W'(q.pop_cnt_i);
        eff_pop   = (pop_req > count_q) ? count_q : pop_req;
        wr_ptr_d  = wr_ptr_q + PTR_W'(npush_acc);
        rd_ptr_d  = rd_ptr_q + PTR_W'(eff_pop);
        count_d   = count_q + npush_acc - eff_pop;
        if (q.flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // State register; storage is excluded so it needs no reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Write decode: valid lanes go to consecutive slots from wr_ptr
    always_comb begin
        for (int k = 0; k < FETCH_W; k++) begin
            wr_en[k]  = allowin && !q.flush_i && q.push_valid_i[k];
            wr_idx[k] = wr_ptr_q + PTR_W'(lane_off[k]);
        end
    end

    // Storage write; distinct lanes always target distinct slots
    always_ff @(posedge clk) begin
        for (int k = 0; k < FETCH_W; k++) begin
            if (wr_en[k]) begin
                mem_q[wr_idx[k]] <= q.push_data_i[k*ENTRY_W +: ENTRY_W];
            end
        end
    end

    // Head read mux: lane j shows slot rd_ptr+j, valid as a thermometer
    always_comb begin
        for (int j = 0; j < ISSUE_W; j++) begin
            head_valid[j]                   = (count_q > CNT_W'(j));
            head_data[j*ENTRY_W +: ENTRY_W] = mem_q[rd_ptr_q + PTR_W'(j)];
        end
    end

    assign q.allowin_o     = allowin;
    assign q.almost_full_o = almost_full;
    assign q.count_o       = count_q;
    assign q.head_valid_o  = head_valid;
    assign q.head_data_o   = head_data;

endmodule
